serial_xfer_ctrl: RTL and testbench
===================================

SERIAL_XFER_CTRL -- requirements
Module: serial_xfer_ctrl

Interface
REQ-001 Parameter BITS, default 8: word length, equal to the companion serial_duplex BITS.
REQ-002 Parameter MAX_WORDS, default 16: maximum words per phase; CW = $clog2(MAX_WORDS+1).
REQ-003 Port serial_clk  input  1: serial clock; the block uses the rising edge only.
REQ-004 Port in_rst  input  1: reset, asynchronous, active-high.
REQ-005 Port in_start  input  1: one-cycle request to begin a transaction.
REQ-006 Port in_num_tx  input  CW: number of words to send (FPGA -> IC), sampled at start.
REQ-007 Port in_num_rx  input  CW: number of words to receive (IC -> FPGA), sampled at start.
REQ-008 Port in_tx_word  input  BITS: current word to send, held stable by upstream until out_tx_req.
REQ-009 Port out_tx_req  output  1: one-cycle pulse; the current tx word is consumed and upstream presents the next one.
REQ-010 Port out_rx_valid  output  1: one-cycle pulse; out_rx_word holds a received word.
REQ-011 Port out_rx_word  output  BITS: received word.
REQ-012 Port out_busy  output  1: high when the state is not Idle.
REQ-013 Port out_done  output  1: one-cycle pulse at the end of the transaction.
REQ-014 Port out_enable_fromfpga  output  1: drives serial_duplex in_enable_fromfpga.
REQ-015 Port out_enable_tofpga  output  1: drives serial_duplex in_enable_tofpga.
REQ-016 Port out_parallel  output  BITS: drives serial_duplex in_parallel.
REQ-017 Port in_next_word_fromfpga  input  1: serial_duplex out_next_word_fromfpga.
REQ-018 Port in_next_word_tofpga  input  1: serial_duplex out_next_word_tofpga.
REQ-019 Port in_parallel  input  BITS: serial_duplex out_parallel.

Function
REQ-020 FSM states SHALL be Idle, Tx, Rx and Done; state, counters and pulse outputs SHALL be registered on the rising edge of serial_clk.
REQ-021 In Idle, on in_start: latch the two word counts; go to Tx if num_tx>0, else to Rx if num_rx>0, else to Done.
REQ-022 in_start SHALL be ignored while out_busy=1.
REQ-023 In Tx: out_enable_fromfpga=1 (combinational from state) and out_parallel=in_tx_word; otherwise out_parallel SHALL be 0.
REQ-024 In Tx, on in_next_word_fromfpga: increment tx_ctr and pulse out_tx_req on the next cycle.
REQ-025 When tx_ctr reaches num_tx, the same edge SHALL leave Tx, going to Rx if num_rx>0, else to Done.
REQ-026 Leaving Tx on that edge SHALL ensure the serial_duplex never starts an extra word.
REQ-027 In Rx: out_enable_tofpga=1 (combinational from state).
REQ-028 In Rx, on in_next_word_tofpga: increment rx_ctr and register out_rx_valid=1 on the next cycle, with out_rx_word=in_parallel during that cycle.
REQ-029 In Rx, when rx_ctr reaches num_rx, the next state SHALL be Done.
REQ-030 Done SHALL last exactly one cycle: out_done=1 with busy still high, then return to Idle.
REQ-031 Counters SHALL be CW bits wide.
REQ-032 Counts greater than MAX_WORDS SHALL be saturated to MAX_WORDS at latch.
REQ-033 Counters SHALL clear in Idle.

Reset
REQ-034 On in_rst, including mid-transaction: state=Idle, counters=0, and all outputs 0 (enables, tx_req, rx_valid, rx_word, done, busy).
REQ-035 A mid-transaction reset SHALL NOT produce an out_done pulse.

Configuration
REQ-036 With SERIAL_XFER_CS_EN defined: add port out_cs (output, 1 bit, active-low chip select).
REQ-037 out_cs SHALL be 0 from the cycle after the start is accepted through Done.
REQ-038 out_cs SHALL stay 0 for one additional guard cycle in a Guard state inserted between Done and Idle; busy stays high during Guard.
REQ-039 out_cs SHALL reset to 1.
REQ-040 Without SERIAL_XFER_CS_EN: no out_cs port and no Guard state.

Structure
REQ-041 The state enum t_serial_xfer_state SHALL live in the shared package serial_pkg.
REQ-042 No sub-module is instantiated.
REQ-043 Top-level integration pairs this block with a serial_duplex set to FROM_FPGA_FALLING_EDGE=0 and TO_FPGA_FALLING_EDGE=0, clocked from its out_clk_raw.

Verification
REQ-044 Scenario: start with num_tx=2, num_rx=0, tx words 0xA5, 0x3C -> IC sees 16 bits LSB-first, two out_tx_req pulses, out_done 1 cycle after the last bit, no 17th bit.
REQ-045 Scenario: num_tx=1, num_rx=2, IC drives 0x81, 0x7E -> out_rx_valid pulses twice with 0x81 then 0x7E, and the enables never overlap.
REQ-046 Scenario: num_tx=0, num_rx=0 -> Idle, Done, Idle in 2 cycles; out_done=1 and both enables stay 0.
REQ-047 Scenario: in_start pulsed again mid-Tx -> ignored; word counts are unchanged.
REQ-048 Scenario: in_rst asserted at bit 3 of word 1 -> all outputs 0 immediately and no done; a fresh start then completes normally.
REQ-049 Scenario: with SERIAL_XFER_CS_EN, num_tx=1 -> out_cs low from the cycle after start through the Guard cycle, then high.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types for the serial transfer blocks.
// The optional Guard state exists only when SERIAL_XFER_CS_EN is defined.
package serial_pkg;

`ifdef SERIAL_XFER_CS_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_DONE,
        ST_GUARD
    } t_serial_xfer_state;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_DONE
    } t_serial_xfer_state;
`endif

    // Clamp a requested word count to the per-phase maximum.
    function automatic int unsigned sat_count(input int unsigned count, input int unsigned max_count);
        return (count > max_count) ? max_count : count;
    endfunction

endpackage

// File: rtl/serial_xfer_ctrl.sv
// Word-level sequencer for serial_duplex: sends num_tx words, then receives num_rx words.
// Define SERIAL_XFER_CS_EN to add an active-low chip select with a trailing Guard cycle.
module serial_xfer_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned MAX_WORDS = 16,
    localparam int unsigned CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic            serial_clk,
    input  logic            in_rst,
    input  logic            in_start,
    input  logic [CW-1:0]   in_num_tx,
    input  logic [CW-1:0]   in_num_rx,
    input  logic [BITS-1:0] in_tx_word,
    output logic            out_tx_req,
    output logic            out_rx_valid,
    output logic [BITS-1:0] out_rx_word,
    output logic            out_busy,
    output logic            out_done,
    output logic            out_enable_fromfpga,
    output logic            out_enable_tofpga,
    output logic [BITS-1:0] out_parallel,
    input  logic            in_next_word_fromfpga,
    input  logic            in_next_word_tofpga,
    input  logic [BITS-1:0] in_parallel
`ifdef SERIAL_XFER_CS_EN
    ,
    output logic            out_cs
`endif
);

    t_serial_xfer_state state, state_next;

    logic [CW-1:0] num_tx, num_rx;
    logic [CW-1:0] tx_ctr, rx_ctr;
    logic [CW-1:0] start_tx, start_rx;
    logic          tx_last, rx_last;

    assign start_tx = CW'(sat_count(32'(in_num_tx), MAX_WORDS));
    assign start_rx = CW'(sat_count(32'(in_num_rx), MAX_WORDS));
    assign tx_last  = ((tx_ctr + CW'(1)) == num_tx);
    assign rx_last  = ((rx_ctr + CW'(1)) == num_rx);

    // Enables and tx data follow the state directly so leaving Tx stops the next word.
    assign out_busy            = (state != ST_IDLE);
    assign out_enable_fromfpga = (state == ST_TX);
    assign out_enable_tofpga   = (state == ST_RX);
    assign out_parallel        = (state == ST_TX) ? in_tx_word : '0;

    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_start) begin
                    if (start_tx != '0) begin
                        state_next = ST_TX;
                    end else if (start_rx != '0) begin
                        state_next = ST_RX;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_TX: begin
                if (in_next_word_fromfpga && tx_last) begin
                    state_next = (num_rx != '0) ? ST_RX : ST_DONE;
                end
            end
            ST_RX: begin
                if (in_next_word_tofpga && rx_last) begin
                    state_next = ST_DONE;
                end
            end
`ifdef SERIAL_XFER_CS_EN
            ST_DONE:  state_next = ST_GUARD;
            ST_GUARD: state_next = ST_IDLE;
`else
            ST_DONE:  state_next = ST_IDLE;
`endif
            default:  state_next = ST_IDLE;
        endcase
    end

    // Word counts, progress counters and registered pulses.
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            num_tx       <= '0;
            num_rx       <= '0;
            tx_ctr       <= '0;
            rx_ctr       <= '0;
            out_tx_req   <= 1'b0;
            out_rx_valid <= 1'b0;
            out_rx_word  <= '0;
            out_done     <= 1'b0;
        end else begin
            out_tx_req   <= (state == ST_TX) && in_next_word_fromfpga;
            out_rx_valid <= (state == ST_RX) && in_next_word_tofpga;
            out_done     <= (state_next == ST_DONE);
            if ((state == ST_RX) && in_next_word_tofpga) begin
                out_rx_word <= in_parallel;
            end
            case (state)
                ST_IDLE: begin
                    tx_ctr <= '0;
                    rx_ctr <= '0;
                    if (in_start) begin
                        num_tx <= start_tx;
                        num_rx <= start_rx;
                    end
                end
                ST_TX: begin
                    if (in_next_word_fromfpga) begin
                        tx_ctr <= tx_ctr + CW'(1);
                    end
                end
                ST_RX: begin
                    if (in_next_word_tofpga) begin
                        rx_ctr <= rx_ctr + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_XFER_CS_EN
    // Chip select is asserted whenever the controller will be out of Idle.
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            out_cs <= 1'b1;
        end else begin
            out_cs <= (state_next == ST_IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Randomised bench for serial_xfer_ctrl against a word-count reference model,
// with an emulated serial_duplex peer and upstream word source.
module tb_serial_xfer_ctrl;

    localparam int unsigned BITS      = 8;
    localparam int unsigned MAX_WORDS = 16;
    localparam int unsigned CW        = $clog2(MAX_WORDS + 1);
`ifdef SERIAL_XFER_CS_EN
    localparam bit HAS_CS = 1'b1;
`else
    localparam bit HAS_CS = 1'b0;
`endif

    logic            serial_clk = 1'b0;
    logic            in_rst = 1'b1;
    logic            in_start = 1'b0;
    logic [CW-1:0]   in_num_tx = '0;
    logic [CW-1:0]   in_num_rx = '0;
    logic [BITS-1:0] in_tx_word;
    logic            out_tx_req, out_rx_valid, out_busy, out_done;
    logic [BITS-1:0] out_rx_word, out_parallel;
    logic            out_enable_fromfpga, out_enable_tofpga;
    logic            in_next_word_fromfpga = 1'b0;
    logic            in_next_word_tofpga = 1'b0;
    logic [BITS-1:0] in_parallel = '0;
`ifdef SERIAL_XFER_CS_EN
    logic            out_cs;
`endif

    serial_xfer_ctrl #(.BITS(BITS), .MAX_WORDS(MAX_WORDS)) dut (
        .serial_clk            (serial_clk),
        .in_rst                (in_rst),
        .in_start              (in_start),
        .in_num_tx             (in_num_tx),
        .in_num_rx             (in_num_rx),
        .in_tx_word            (in_tx_word),
        .out_tx_req            (out_tx_req),
        .out_rx_valid          (out_rx_valid),
        .out_rx_word           (out_rx_word),
        .out_busy              (out_busy),
        .out_done              (out_done),
        .out_enable_fromfpga   (out_enable_fromfpga),
        .out_enable_tofpga     (out_enable_tofpga),
        .out_parallel          (out_parallel),
        .in_next_word_fromfpga (in_next_word_fromfpga),
        .in_next_word_tofpga   (in_next_word_tofpga),
        .in_parallel           (in_parallel)
`ifdef SERIAL_XFER_CS_EN
        ,
        .out_cs                (out_cs)
`endif
    );

    always #5 serial_clk = ~serial_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > int'(MAX_WORDS)) ? int'(MAX_WORDS) : v;
    endfunction

    // Upstream source: presents up_words[up_idx], advancing on each tx request.
    logic [BITS-1:0] up_words [0:31];
    logic [4:0]      up_idx = '0;
    assign in_tx_word = up_words[up_idx];

    always @(posedge serial_clk) begin
        #1;
        if (out_tx_req) up_idx = up_idx + 5'd1;
    end

    // Emulated serial_duplex: one word boundary every peer_gap enabled cycles.
    logic [BITS-1:0] peer_words [0:31];
    logic [4:0]      peer_idx = '0;
    int              peer_gap = 8;
    int              cnt_from = 0;
    int              cnt_to = 0;

    always @(posedge serial_clk) begin
        #1;
        in_next_word_fromfpga = 1'b0;
        in_next_word_tofpga   = 1'b0;
        in_parallel           = BITS'($urandom);
        if (in_rst) begin
            cnt_from = 0;
            cnt_to   = 0;
        end else begin
            if (out_enable_fromfpga) begin
                if (cnt_from >= peer_gap - 1) begin
                    in_next_word_fromfpga = 1'b1;
                    cnt_from = 0;
                end else cnt_from++;
            end else cnt_from = 0;
            if (out_enable_tofpga) begin
                if (cnt_to >= peer_gap - 1) begin
                    in_next_word_tofpga = 1'b1;
                    in_parallel = peer_words[peer_idx];
                    peer_idx = peer_idx + 5'd1;
                    cnt_to = 0;
                end else cnt_to++;
            end else cnt_to = 0;
        end
    end

    // Reference model: stage 0 idle, 1 moving words, 2 done, 3 guard; tracks words left.
    int              m_stage = 0;
    int              m_tx_left = 0;
    int              m_rx_left = 0;
    logic            m_tx_req = 1'b0;
    logic            m_rx_valid = 1'b0;
    logic [BITS-1:0] m_rx_word = '0;

    always @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            m_stage = 0; m_tx_left = 0; m_rx_left = 0;
            m_tx_req = 1'b0; m_rx_valid = 1'b0; m_rx_word = '0;
        end else begin
            m_tx_req   = (m_stage == 1) && (m_tx_left > 0) && in_next_word_fromfpga;
            m_rx_valid = (m_stage == 1) && (m_tx_left == 0) && (m_rx_left > 0) && in_next_word_tofpga;
            if (m_rx_valid) m_rx_word = in_parallel;
            case (m_stage)
                0: if (in_start) begin
                    m_tx_left = sat(int'(in_num_tx));
                    m_rx_left = sat(int'(in_num_rx));
                    m_stage = (m_tx_left + m_rx_left > 0) ? 1 : 2;
                end
                1: begin
                    if (m_tx_left > 0) begin
                        if (in_next_word_fromfpga) m_tx_left--;
                    end else if (in_next_word_tofpga) m_rx_left--;
                    if (m_tx_left == 0 && m_rx_left == 0) m_stage = 2;
                end
                2: m_stage = HAS_CS ? 3 : 0;
                default: m_stage = 0;
            endcase
        end
    end

    // Per-cycle compare and transaction monitor.
    logic            chk_en = 1'b0;
    int              cyc = 0;
    int              tx_cnt = 0;
    int              done_cnt = 0;
    int              last_tx_cyc = 0;
    int              done_cyc = 0;
    logic [BITS-1:0] cap_tx[$];
    logic [BITS-1:0] cap_rx[$];

    always @(negedge serial_clk) begin
        logic exp_from, exp_to;
        cyc++;
        exp_from = (m_stage == 1) && (m_tx_left > 0);
        exp_to   = (m_stage == 1) && (m_tx_left == 0) && (m_rx_left > 0);
        if (chk_en) begin
            check("busy", 32'(out_busy), 32'(m_stage != 0));
            check("en_fromfpga", 32'(out_enable_fromfpga), 32'(exp_from));
            check("en_tofpga", 32'(out_enable_tofpga), 32'(exp_to));
            check("en_overlap", 32'(out_enable_fromfpga & out_enable_tofpga), 32'(0));
            check("parallel", 32'(out_parallel), exp_from ? 32'(in_tx_word) : 32'(0));
            check("tx_req", 32'(out_tx_req), 32'(m_tx_req));
            check("rx_valid", 32'(out_rx_valid), 32'(m_rx_valid));
            check("rx_word", 32'(out_rx_word), 32'(m_rx_word));
            check("done", 32'(out_done), 32'(m_stage == 2));
`ifdef SERIAL_XFER_CS_EN
            check("cs", 32'(out_cs), 32'(m_stage == 0));
`endif
        end
        if (in_next_word_fromfpga && out_enable_fromfpga) begin
            cap_tx.push_back(out_parallel);
            last_tx_cyc = cyc;
        end
        if (out_tx_req) tx_cnt++;
        if (out_rx_valid) cap_rx.push_back(out_rx_word);
        if (out_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_monitor();
        up_idx = '0;
        peer_idx = '0;
        tx_cnt = 0;
        done_cnt = 0;
        cap_tx.delete();
        cap_rx.delete();
    endtask

    task automatic pulse_start(input int ntx, input int nrx);
        @(posedge serial_clk); #1;
        in_num_tx = CW'(ntx);
        in_num_rx = CW'(nrx);
        in_start  = 1'b1;
        @(posedge serial_clk); #1;
        in_start  = 1'b0;
    endtask

    // Full transaction with optional ignored restart while busy, then scoreboard checks.
    task automatic run_xfer(input int ntx, input int nrx, input int gap, input bit mid_start);
        bit seen = 1'b0;
        clear_monitor();
        peer_gap = gap;
        pulse_start(ntx, nrx);
        for (int i = 0; i < 2000; i++) begin
            if (out_done) begin
                seen = 1'b1;
                break;
            end
            in_start = 1'b0;
            if (mid_start && i == 3 && out_busy) begin
                in_num_tx = CW'($urandom_range(0, 3));
                in_num_rx = CW'($urandom_range(0, 3));
                in_start  = 1'b1;
            end
            @(posedge serial_clk); #1;
        end
        in_start = 1'b0;
        if (!seen) check("done_timeout", 32'(0), 32'(1));
        repeat (3) @(posedge serial_clk);
        #1;
        check("tx_words", 32'(cap_tx.size()), 32'(sat(ntx)));
        check("rx_words", 32'(cap_rx.size()), 32'(sat(nrx)));
        check("done_pulses", 32'(done_cnt), 32'(1));
        foreach (cap_tx[i]) check("tx_data", 32'(cap_tx[i]), 32'(up_words[i]));
        foreach (cap_rx[i]) check("rx_data", 32'(cap_rx[i]), 32'(peer_words[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            up_words[i]   = BITS'($urandom);
            peer_words[i] = BITS'($urandom);
        end
        repeat (3) @(posedge serial_clk);
        #1 in_rst = 1'b0;
        @(negedge serial_clk);
        chk_en = 1'b1;
        check("reset_busy", 32'(out_busy), 32'(0));
        check("reset_done", 32'(out_done), 32'(0));
        check("reset_rx_word", 32'(out_rx_word), 32'(0));
`ifdef SERIAL_XFER_CS_EN
        check("reset_cs", 32'(out_cs), 32'(1));
`endif

        // Two words out, nothing back.
        up_words[0] = 8'hA5;
        up_words[1] = 8'h3C;
        run_xfer(2, 0, BITS, 1'b0);
        check("s1_tx_req_pulses", 32'(tx_cnt), 32'(2));
        check("s1_word0", 32'(cap_tx[0]), 32'h0000_00A5);
        check("s1_word1", 32'(cap_tx[1]), 32'h0000_003C);
        check("s1_done_latency", 32'(done_cyc - last_tx_cyc), 32'(1));
        repeat (4) @(posedge serial_clk);
        #1 check("s1_no_extra_word", 32'(cap_tx.size()), 32'(2));

        // One word out, two back.
        peer_words[0] = 8'h81;
        peer_words[1] = 8'h7E;
        run_xfer(1, 2, BITS, 1'b0);
        check("s2_rx0", 32'(cap_rx[0]), 32'h0000_0081);
        check("s2_rx1", 32'(cap_rx[1]), 32'h0000_007E);

        // Empty transaction: Idle, Done, Idle.
        clear_monitor();
        pulse_start(0, 0);
        @(negedge serial_clk);
        check("s3_done", 32'(out_done), 32'(1));
        check("s3_busy", 32'(out_busy), 32'(1));
        check("s3_enables", 32'({out_enable_fromfpga, out_enable_tofpga}), 32'(0));
        @(negedge serial_clk);
        check("s3_done_gone", 32'(out_done), 32'(0));
        check("s3_busy_after", 32'(out_busy), 32'(HAS_CS));
        repeat (2) @(negedge serial_clk);
        check("s3_idle", 32'(out_busy), 32'(0));

        // Restart request while busy must be ignored.
        run_xfer(3, 1, 4, 1'b1);

        // Counts above the maximum saturate.
        run_xfer(20, 0, 1, 1'b0);
        check("sat_tx_words", 32'(cap_tx.size()), 32'(16));
        run_xfer(0, 31, 1, 1'b0);
        check("sat_rx_words", 32'(cap_rx.size()), 32'(16));

        // Reset part-way through the second word.
        clear_monitor();
        peer_gap = BITS;
        pulse_start(2, 1);
        for (int i = 0; i < 200 && tx_cnt < 1; i++) @(posedge serial_clk);
        repeat (3) @(posedge serial_clk);
        #1 in_rst = 1'b1;
        @(negedge serial_clk);
        check("rst_busy", 32'(out_busy), 32'(0));
        check("rst_enables", 32'({out_enable_fromfpga, out_enable_tofpga}), 32'(0));
        check("rst_pulses", 32'({out_tx_req, out_rx_valid, out_done}), 32'(0));
        check("rst_data", 32'({out_parallel, out_rx_word}), 32'(0));
        repeat (2) @(posedge serial_clk);
        #1 in_rst = 1'b0;
        repeat (3) @(posedge serial_clk);
        #1 check("rst_no_done", 32'(done_cnt), 32'(0));
        run_xfer(1, 1, 3, 1'b0);

        // Randomised transactions.
        for (int t = 0; t < 40; t++) begin
            int ntx, nrx;
            for (int i = 0; i < 32; i++) begin
                up_words[i]   = BITS'($urandom);
                peer_words[i] = BITS'($urandom);
            end
            ntx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2 ** CW - 1)) : int'($urandom_range(0, 5));
            nrx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2 ** CW - 1)) : int'($urandom_range(0, 5));
            run_xfer(ntx, nrx, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
